accelerator_property_count_p: RTL and testbench

- Parametrised successor to the fixed 8-bit even-element counter.
- Splits each DATA_W input word into ELEM_W elements and evaluates LANES elements per cycle against a runtime-selected property.
- Accumulates matches across operations into a CNT_W counter.
- Sits behind the NDP command interface:
  - start_i launches one word.
  - done_o pulses when count_o holds the committed running total.

---
 rtl/accelerator_property_count_p.sv | 129 ++++++++++++
 tb/tb_accelerator_property_count_p.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_property_count_p.sv
// Property counter: scans a DATA_W word LANES elements per cycle and accumulates matches.
// Optional macro PROP_CNT_SAT_EN makes the accumulator saturate instead of wrapping.
module accelerator_property_count_p #(
   parameter int DATA_W = 32,
   parameter int ELEM_W = 8,
   parameter int LANES  = 2,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic [2:0]        mode_i,
   input  logic [ELEM_W-1:0] key_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CNT_W-1:0]  count_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o
);
   localparam int NUM_ELEM = DATA_W / ELEM_W;
   localparam int NUM_GRP  = NUM_ELEM / LANES;
   localparam int GRP_W    = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
   localparam int POP_W    = $clog2(LANES + 1);
   localparam int SUM_W    = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
   localparam int SHIFT_W  = LANES * ELEM_W;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t            state_q;
   logic              start_prev_q;
   logic [DATA_W-1:0] data_q;
   logic [2:0]        mode_q;
   logic [ELEM_W-1:0] key_q;
   logic [GRP_W-1:0]  grp_q;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  count_q;
   logic              done_q;
   logic              ovf_q;

   logic [LANES-1:0]  lane_match;
   logic [POP_W-1:0]  pop;
   logic [SUM_W-1:0]  sum;
   logic              sum_ovf;
   logic [CNT_W-1:0]  acc_d;
   logic              start_acc;

   // The captured word shifts down each SCAN cycle, so the current group always sits in the low lanes.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [ELEM_W-1:0] elem;
         assign elem = data_q[gi*ELEM_W +: ELEM_W];
         assign lane_match[gi] = (mode_q == 3'd0) ? ~elem[0] :
                                 (mode_q == 3'd1) ?  elem[0] :
                                 (mode_q == 3'd2) ? (elem == '0) :
                                 (mode_q == 3'd3) ? (elem == key_q) :
                                 (mode_q == 3'd4) ? (elem >  key_q) :
                                 (mode_q == 3'd5) ? (elem <  key_q) : 1'b0;
      end
   endgenerate

   always_comb begin
      pop = '0;
      for (int l = 0; l < LANES; l++) begin
         pop = pop + POP_W'(lane_match[l]);
      end
      sum     = SUM_W'(acc_q) + SUM_W'(pop);
      sum_ovf = |sum[SUM_W-1:CNT_W];
`ifdef PROP_CNT_SAT_EN
      acc_d   = sum_ovf ? '1 : sum[CNT_W-1:0];
`else
      acc_d   = sum[CNT_W-1:0];
`endif
   end

   assign start_acc = start_i && !start_prev_q && (state_q == IDLE);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b1;
         data_q       <= '0;
         mode_q       <= '0;
         key_q        <= '0;
         grp_q        <= '0;
         acc_q        <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         start_prev_q <= start_i;
         done_q       <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear_i) begin
                  acc_q   <= '0;
                  count_q <= '0;
                  ovf_q   <= 1'b0;
               end
               if (start_acc) begin
                  data_q  <= data_i;
                  mode_q  <= mode_i;
                  key_q   <= key_i;
                  grp_q   <= '0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               acc_q  <= acc_d;
               if (sum_ovf) ovf_q <= 1'b1;
               data_q <= data_q >> SHIFT_W;
               grp_q  <= grp_q + 1'b1;
               if (grp_q == GRP_W'(NUM_GRP - 1)) state_q <= DONE;
            end
            DONE: begin
               count_q <= acc_q;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q != IDLE);
   assign done_o  = done_q;
   assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_accelerator_property_count_p.sv
// Bench: four instances (LANES=2/1/4, and CNT_W=3) driven by directed tables, sequences and a reference model.
module tb_accelerator_property_count_p;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        arstn;
   logic        start_s [4];
   logic        clear_s [4];
   logic [2:0]  mode_s  [4];
   logic [7:0]  key_s   [4];
   logic [31:0] data_s  [4];
   logic [31:0] cnt_a   [3];
   logic [2:0]  cnt3;
   logic        busy_a  [4];
   logic        done_a  [4];
   logic        ovf_a   [4];

   int n_cmp = 0;
   int n_bad = 0;

   accelerator_property_count_p #(.DATA_W(32), .ELEM_W(8), .LANES(2), .CNT_W(32)) u_l2 (
      .clk_i(clk), .arstn_i(arstn), .start_i(start_s[0]), .clear_i(clear_s[0]),
      .mode_i(mode_s[0]), .key_i(key_s[0]), .data_i(data_s[0]),
      .count_o(cnt_a[0]), .busy_o(busy_a[0]), .done_o(done_a[0]), .ovf_o(ovf_a[0]));

   accelerator_property_count_p #(.DATA_W(32), .ELEM_W(8), .LANES(1), .CNT_W(32)) u_l1 (
      .clk_i(clk), .arstn_i(arstn), .start_i(start_s[1]), .clear_i(clear_s[1]),
      .mode_i(mode_s[1]), .key_i(key_s[1]), .data_i(data_s[1]),
      .count_o(cnt_a[1]), .busy_o(busy_a[1]), .done_o(done_a[1]), .ovf_o(ovf_a[1]));

   accelerator_property_count_p #(.DATA_W(32), .ELEM_W(8), .LANES(4), .CNT_W(32)) u_l4 (
      .clk_i(clk), .arstn_i(arstn), .start_i(start_s[2]), .clear_i(clear_s[2]),
      .mode_i(mode_s[2]), .key_i(key_s[2]), .data_i(data_s[2]),
      .count_o(cnt_a[2]), .busy_o(busy_a[2]), .done_o(done_a[2]), .ovf_o(ovf_a[2]));

   accelerator_property_count_p #(.DATA_W(32), .ELEM_W(8), .LANES(2), .CNT_W(3)) u_c3 (
      .clk_i(clk), .arstn_i(arstn), .start_i(start_s[3]), .clear_i(clear_s[3]),
      .mode_i(mode_s[3]), .key_i(key_s[3]), .data_i(data_s[3]),
      .count_o(cnt3), .busy_o(busy_a[3]), .done_o(done_a[3]), .ovf_o(ovf_a[3]));

   typedef struct {
      logic [2:0]  m;
      logic [7:0]  k;
      logic [31:0] d;
      logic        clr;
      logic [31:0] exp;
   } vec_t;

   function automatic logic [31:0] get_cnt(input int u);
      if (u == 3) return {29'd0, cnt3};
      return cnt_a[u];
   endfunction

   function automatic int exp_lat(input int u);
      if (u == 1) return 5;
      if (u == 2) return 2;
      return 3;
   endfunction

   function automatic int ref_pop(input logic [2:0] m, input logic [7:0] k, input logic [31:0] d);
      int n;
      logic [7:0] e;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         e = d[i*8 +: 8];
         case (m)
            3'd0: n += (e[0] == 1'b0) ? 1 : 0;
            3'd1: n += (e[0] == 1'b1) ? 1 : 0;
            3'd2: n += (e == 8'd0) ? 1 : 0;
            3'd3: n += (e == k) ? 1 : 0;
            3'd4: n += (e > k) ? 1 : 0;
            3'd5: n += (e < k) ? 1 : 0;
            default: n += 0;
         endcase
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   // One operation: start edge before edge 0, then wait (bounded) for done_o; lat = edges after edge 0.
   task automatic op(input int u, input logic [2:0] m, input logic [7:0] k, input logic [31:0] d,
                     input logic clr, output logic [31:0] cnt, output int lat);
      @(negedge clk);
      start_s[u] = 1'b1; clear_s[u] = clr; mode_s[u] = m; key_s[u] = k; data_s[u] = d;
      @(negedge clk);
      start_s[u] = 1'b0; clear_s[u] = 1'b0; mode_s[u] = ~m; key_s[u] = ~k; data_s[u] = ~d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done_a[u] && lat < 20);
      if (!done_a[u]) lat = -1;
      cnt = get_cnt(u);
      $display("op unit=%0d mode=%0d key=0x%02h data=0x%08h clr=%0b -> count=0x%0h lat=%0d ovf=%0b",
               u, m, k, d, clr, cnt, lat, ovf_a[u]);
   endtask

   initial begin
      vec_t        tbl [13];
      logic [31:0] cnt;
      int          lat;
      int          nd;
      int          nbusy;
      logic [31:0] acc_ref;
      logic [2:0]  rm;
      logic [7:0]  rk;
      logic [31:0] rd;

      tbl[0]  = '{3'd0, 8'h00, 32'h01020304, 1'b0, 32'd2};
      tbl[1]  = '{3'd0, 8'h00, 32'h05060708, 1'b0, 32'd4};
      tbl[2]  = '{3'd0, 8'h00, 32'h090A0B0C, 1'b0, 32'd6};
      tbl[3]  = '{3'd3, 8'h07, 32'h07000707, 1'b1, 32'd3};
      tbl[4]  = '{3'd4, 8'h80, 32'hFF81807F, 1'b1, 32'd2};
      tbl[5]  = '{3'd5, 8'h80, 32'hFF81807F, 1'b0, 32'd3};
      tbl[6]  = '{3'd6, 8'h80, 32'hFF81807F, 1'b0, 32'd3};
      tbl[7]  = '{3'd2, 8'h00, 32'h00FF0000, 1'b1, 32'd3};
      tbl[8]  = '{3'd1, 8'h00, 32'h01020304, 1'b0, 32'd5};
      tbl[9]  = '{3'd3, 8'h55, 32'h55AA5500, 1'b0, 32'd7};
      tbl[10] = '{3'd4, 8'hFE, 32'hFFFEFF00, 1'b0, 32'd9};
      tbl[11] = '{3'd7, 8'h00, 32'h00000000, 1'b0, 32'd9};
      tbl[12] = '{3'd5, 8'h00, 32'h12345678, 1'b0, 32'd9};

      for (int u = 0; u < 4; u++) begin
         start_s[u] = 1'b0; clear_s[u] = 1'b0; mode_s[u] = '0; key_s[u] = '0; data_s[u] = '0;
      end
      arstn = 1'b0;
      repeat (3) @(negedge clk);
      arstn = 1'b1;
      @(negedge clk);
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("reset_count_u%0d", u), get_cnt(u), 32'd0);
         chk($sformatf("reset_busy_u%0d", u), 32'(busy_a[u]), 32'd0);
         chk($sformatf("reset_done_u%0d", u), 32'(done_a[u]), 32'd0);
         chk($sformatf("reset_ovf_u%0d", u), 32'(ovf_a[u]), 32'd0);
      end

      for (int i = 0; i < 13; i++) begin
         op(0, tbl[i].m, tbl[i].k, tbl[i].d, tbl[i].clr, cnt, lat);
         chk($sformatf("tbl%0d_count", i), cnt, tbl[i].exp);
         chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
      end

      // clear honoured in IDLE
      @(negedge clk); clear_s[0] = 1'b1;
      @(negedge clk); clear_s[0] = 1'b0;
      chk("clear_idle_count", cnt_a[0], 32'd0);

      // start held high for 5 cycles launches a single operation
      @(negedge clk);
      start_s[0] = 1'b1; mode_s[0] = 3'd0; data_s[0] = 32'h01020304;
      nd = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 4) start_s[0] = 1'b0;
         if (done_a[0]) nd++;
      end
      chk("held_start_dones", 32'(nd), 32'd1);
      chk("held_start_count", cnt_a[0], 32'd2);

      // start edge and clear_i during SCAN are both ignored
      @(negedge clk);
      start_s[0] = 1'b1; mode_s[0] = 3'd0; data_s[0] = 32'h01020304;
      nd = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 0) start_s[0] = 1'b0;
         if (c == 1) begin start_s[0] = 1'b1; clear_s[0] = 1'b1; end
         if (c == 2) begin start_s[0] = 1'b0; clear_s[0] = 1'b0; end
         if (done_a[0]) nd++;
      end
      chk("scan_start_dones", 32'(nd), 32'd1);
      chk("scan_clear_ignored_count", cnt_a[0], 32'd4);

      // reset in the second SCAN cycle aborts; start held through release is not accepted
      @(negedge clk);
      start_s[0] = 1'b1; mode_s[0] = 3'd0; data_s[0] = 32'h01020304;
      @(negedge clk); start_s[0] = 1'b0;
      @(negedge clk);
      arstn = 1'b0;
      #1;
      chk("midreset_count", cnt_a[0], 32'd0);
      chk("midreset_busy", 32'(busy_a[0]), 32'd0);
      start_s[0] = 1'b1;
      repeat (2) @(negedge clk);
      arstn = 1'b1;
      nd = 0; nbusy = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done_a[0]) nd++;
         if (busy_a[0]) nbusy++;
      end
      chk("held_through_reset_dones", 32'(nd), 32'd0);
      chk("held_through_reset_busy", 32'(nbusy), 32'd0);
      chk("held_through_reset_count", cnt_a[0], 32'd0);
      start_s[0] = 1'b0;
      op(0, 3'd0, 8'h00, 32'h01020304, 1'b0, cnt, lat);
      chk("after_reset_count", cnt, 32'd2);
      chk("after_reset_latency", 32'(lat), 32'd3);

      // 3-bit accumulator overflow
      op(3, 3'd0, 8'h00, 32'h02040608, 1'b0, cnt, lat);
      chk("c3_first_count", cnt, 32'd4);
      chk("c3_first_ovf", 32'(ovf_a[3]), 32'd0);
      op(3, 3'd0, 8'h00, 32'h02040608, 1'b0, cnt, lat);
`ifdef PROP_CNT_SAT_EN
      chk("c3_second_count", cnt, 32'd7);
`else
      chk("c3_second_count", cnt, 32'd0);
`endif
      chk("c3_second_ovf", 32'(ovf_a[3]), 32'd1);
      op(3, 3'd6, 8'h00, 32'h02040608, 1'b0, cnt, lat);
      chk("c3_sticky_ovf", 32'(ovf_a[3]), 32'd1);
      @(negedge clk); clear_s[3] = 1'b1;
      @(negedge clk); clear_s[3] = 1'b0;
      chk("c3_clear_count", get_cnt(3), 32'd0);
      chk("c3_clear_ovf", 32'(ovf_a[3]), 32'd0);

      // random words against the reference model on the three 32-bit instances
      for (int u = 0; u < 3; u++) begin
         acc_ref = '0;
         for (int i = 0; i < 1000; i++) begin
            rm = 3'($urandom_range(0, 5));
            rk = 8'($urandom);
            rd = $urandom;
            if (i == 0) acc_ref = '0;
            acc_ref = acc_ref + 32'(ref_pop(rm, rk, rd));
            op(u, rm, rk, rd, (i == 0), cnt, lat);
            chk($sformatf("rand_u%0d_%0d_count", u, i), cnt, acc_ref);
            chk($sformatf("rand_u%0d_%0d_latency", u, i), 32'(lat), 32'(exp_lat(u)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
